// File: rtl/pk_link_pkg.sv
// Shared panel-link definitions: command classes, frame tags, frame length and
// status-sequencer state encoding. Frame length follows PK_STATUS_CSUM_EN.
package pk_link_pkg;

  localparam logic [2:0] CMD_STATUS = 3'b110;
  localparam logic [2:0] CMD_ROTARY = 3'b111;

  localparam logic [1:0] TAG_DATA = 2'b00;
  localparam logic [1:0] TAG_IND  = 2'b01;
  localparam logic [1:0] TAG_CSUM = 2'b10;
  localparam logic [5:0] TAG_TAIL = 6'b010000;

`ifdef PK_STATUS_CSUM_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif

  localparam int              IDX_W    = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WSTART,
    ST_WDONE,
    ST_NEXT
  } st_t;

endpackage

// File: rtl/pk_status_frame.sv
// Status frame byte mux: snapshot + byte index -> frame byte.
// PK_STATUS_CSUM_EN appends a 6-bit XOR checksum byte at index 6.
module pk_status_frame
  import pk_link_pkg::*;
(
  input  logic [15:0]      w,
  input  logic [9:0]       ind,
  input  logic [3:0]       rot,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       frame_byte
);

  logic [7:0] b0, b1, b2, b3, b4, b5;

  assign b0 = {CMD_STATUS, 1'b0, rot};
  assign b1 = {TAG_DATA, w[15:10]};
  assign b2 = {TAG_DATA, w[9:4]};
  assign b3 = {TAG_DATA, w[3:0], ind[9:8]};
  assign b4 = {TAG_IND, ind[7:2]};
  assign b5 = {TAG_TAIL, ind[1:0]};

`ifdef PK_STATUS_CSUM_EN
  function automatic logic [5:0] csum6(input logic [7:0] a0, input logic [7:0] a1,
                                       input logic [7:0] a2, input logic [7:0] a3,
                                       input logic [7:0] a4, input logic [7:0] a5);
    return a0[5:0] ^ a1[5:0] ^ a2[5:0] ^ a3[5:0] ^ a4[5:0] ^ a5[5:0];
  endfunction

  logic [7:0] b6;
  assign b6 = {TAG_CSUM, csum6(b0, b1, b2, b3, b4, b5)};
`endif

  always_comb begin
    frame_byte = b0;
    case (idx)
      3'd0:    frame_byte = b0;
      3'd1:    frame_byte = b1;
      3'd2:    frame_byte = b2;
      3'd3:    frame_byte = b3;
      3'd4:    frame_byte = b4;
      3'd5:    frame_byte = b5;
`ifdef PK_STATUS_CSUM_EN
      3'd6:    frame_byte = b6;
`endif
      default: frame_byte = b0;
    endcase
  end

endmodule

// File: rtl/pk_status_tx.sv
// Panel status reporter: arbitrates host polls and periodic auto-reports, then
// streams one snapshot frame over the UART byte/busy handshake. See PK_STATUS_CSUM_EN.
module pk_status_tx
  import pk_link_pkg::*;
#(
  parameter int AUTO_MS   = 0,
  parameter int START_TMO = 8
) (
  input  logic        CLK_EXT,
  input  logic        rst,
  input  logic        tick_1ms,
  input  logic        poll,
  input  logic [15:0] w,
  input  logic [9:0]  ind,
  input  logic [3:0]  rot,
  output logic [7:0]  tx_byte,
  output logic        tx_send,
  input  logic        tx_busy,
  output logic        busy,
  output logic        frame_done
);

  localparam int AUTO_W = (AUTO_MS > 1) ? $clog2(AUTO_MS) : 1;
  localparam int TMO_W  = (START_TMO > 1) ? $clog2(START_TMO) : 1;
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'((AUTO_MS > 0) ? AUTO_MS - 1 : 0);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((START_TMO > 0) ? START_TMO - 1 : 0);

  st_t               state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [TMO_W-1:0]  tmo_cnt, tmo_n;
  logic [AUTO_W-1:0] auto_cnt;
  logic              auto_req;
  logic              pending;
  logic              enter_load;
  logic [15:0]       snap_w;
  logic [9:0]        snap_ind;
  logic [3:0]        snap_rot;
  logic [7:0]        frame_byte;
  logic [7:0]        tx_byte_q;

  // Request side: auto-report divider and the coalescing pending flag
  assign auto_req   = (AUTO_MS != 0) && tick_1ms && (auto_cnt == AUTO_LAST);
  assign enter_load = (state == ST_IDLE) && pending;

  always_ff @(posedge CLK_EXT) begin
    if (rst) begin
      auto_cnt <= '0;
    end else if ((AUTO_MS != 0) && tick_1ms) begin
      if (auto_cnt == AUTO_LAST) auto_cnt <= '0;
      else                       auto_cnt <= auto_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK_EXT) begin
    if (rst) pending <= 1'b0;
    else     pending <= poll | auto_req | (pending & ~enter_load);
  end

  // Snapshot is pure data: captured once per frame, never reset
  always_ff @(posedge CLK_EXT) begin
    if (state == ST_LOAD) begin
      snap_w   <= w;
      snap_ind <= ind;
      snap_rot <= rot;
    end
  end

  pk_status_frame u_frame (
    .w          (snap_w),
    .ind        (snap_ind),
    .rot        (snap_rot),
    .idx        (idx),
    .frame_byte (frame_byte)
  );

  // Sequencer
  always_ff @(posedge CLK_EXT) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      tmo_cnt <= tmo_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    tmo_n      = tmo_cnt;
    tx_send    = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        idx_n   = '0;
        state_n = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_send = 1'b1;
          tmo_n   = '0;
          state_n = ST_WSTART;
        end
      end
      ST_WSTART: begin
        // A UART that never raises busy must not stall the frame
        if (tx_busy)                   state_n = ST_WDONE;
        else if (tmo_cnt == TMO_LAST)  state_n = ST_NEXT;
        else                           tmo_n   = tmo_cnt + 1'b1;
      end
      ST_WDONE: begin
        if (!tx_busy) state_n = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx == LAST_IDX) begin
          frame_done = 1'b1;
          state_n    = ST_IDLE;
        end else begin
          idx_n   = idx + 1'b1;
          state_n = ST_SEND;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // tx_byte is live in the send cycle and held afterwards until the next send
  always_ff @(posedge CLK_EXT) begin
    if (rst)          tx_byte_q <= 8'h00;
    else if (tx_send) tx_byte_q <= frame_byte;
  end

  assign tx_byte = tx_send ? frame_byte : tx_byte_q;

endmodule

// File: tb/tb_pk_status_tx.sv
// Self-checking bench for pk_status_tx: frame contents, latency, hold-off,
// start timeout, request coalescing, auto-report and mid-frame reset.
`timescale 1ns/1ps
module tb_pk_status_tx;

  localparam int AUTO_MS   = 3;
  localparam int START_TMO = 8;
`ifdef PK_STATUS_CSUM_EN
  localparam int NBYTES = 7;
`else
  localparam int NBYTES = 6;
`endif

  typedef logic [6:0][7:0] frame_t;
  typedef struct {
    logic [15:0] w;
    logic [9:0]  ind;
    logic [3:0]  rot;
    logic [47:0] exp;
  } vec_t;

  logic        CLK_EXT = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1ms = 1'b0;
  logic        poll = 1'b0;
  logic [15:0] w = 16'h0;
  logic [9:0]  ind = 10'h0;
  logic [3:0]  rot = 4'h0;
  logic [7:0]  tx_byte;
  logic        tx_send;
  logic        tx_busy;
  logic        busy;
  logic        frame_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  bit uart_en = 1'b1;
  bit hold_busy = 1'b0;
  bit start_q = 1'b0;
  int byte_cyc = 10;
  int ubusy = 0;

  logic [7:0] cap[$];
  int         cap_cyc[$];
  int         done_cycs[$];
  int         done_cnt = 0;
  int         stab_err = 0;
  logic [7:0] last_sent = 8'h00;

  pk_status_tx #(.AUTO_MS(AUTO_MS), .START_TMO(START_TMO)) dut (
    .CLK_EXT    (CLK_EXT),
    .rst        (rst),
    .tick_1ms   (tick_1ms),
    .poll       (poll),
    .w          (w),
    .ind        (ind),
    .rot        (rot),
    .tx_byte    (tx_byte),
    .tx_send    (tx_send),
    .tx_busy    (tx_busy),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #10 CLK_EXT = ~CLK_EXT;

  always @(posedge CLK_EXT) cyc <= cyc + 1;

  // UART model: busy for byte_cyc cycles after each accepted send
  always @(posedge CLK_EXT) begin
    if (start_q && uart_en) ubusy <= byte_cyc;
    else if (ubusy > 0)     ubusy <= ubusy - 1;
  end
  assign tx_busy = (uart_en && (ubusy > 0)) || hold_busy;

  always @(negedge CLK_EXT) begin
    start_q = tx_send;
    if (rst) begin
      last_sent = 8'h00;
    end else begin
      if (tx_send) begin
        cap.push_back(tx_byte);
        cap_cyc.push_back(cyc);
        last_sent = tx_byte;
      end else if (tx_byte !== last_sent) begin
        stab_err++;
      end
      if (frame_done) begin
        done_cnt++;
        done_cycs.push_back(cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic frame_t with_csum(input frame_t f);
    int     x = 0;
    frame_t r = f;
    for (int i = 0; i < 6; i++) x = x ^ (int'(f[i]) % 64);
    r[6] = 8'(128 + x);
    return r;
  endfunction

  function automatic frame_t ref_frame(input logic [15:0] fw, input logic [9:0] fi,
                                       input logic [3:0] fr);
    frame_t f;
    int     wv;
    int     iv;
    wv   = int'(fw);
    iv   = int'(fi);
    f    = '0;
    f[0] = 8'(192 + int'(fr));
    f[1] = 8'(wv / 1024);
    f[2] = 8'((wv / 16) % 64);
    f[3] = 8'((wv % 16) * 4 + iv / 256);
    f[4] = 8'(64 + (iv / 4) % 64);
    f[5] = 8'(64 + iv % 4);
    return with_csum(f);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK_EXT);
    #1;
  endtask

  task automatic pulse_poll(output int pc);
    poll = 1'b1;
    pc   = cyc;
    step(1);
    poll = 1'b0;
  endtask

  task automatic pulse_tick(output int tc);
    tick_1ms = 1'b1;
    tc       = cyc;
    step(1);
    tick_1ms = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    if (done_cnt < target) chk({name, " frame_done timeout"}, done_cnt, target);
  endtask

  task automatic check_frame(input string name, input int base, input frame_t e);
    for (int i = 0; i < NBYTES; i++) begin
      if (base + i < cap.size())
        chk($sformatf("%s B%0d", name, i), {24'd0, cap[base+i]}, {24'd0, e[i]});
      else
        chk($sformatf("%s B%0d missing", name, i), cap.size(), base + i + 1);
    end
  endtask

  task automatic run_poll(input string name, input frame_t e, input bit scramble);
    int base;
    int d0;
    int pc;
    int n;
    base = cap.size();
    d0   = done_cnt;
    pulse_poll(pc);
    n = 0;
    while (cap.size() == base && n < 300) begin
      step(1);
      n++;
    end
    if (scramble) begin
      w   = 16'($urandom);
      ind = 10'($urandom);
      rot = 4'($urandom);
    end
    wait_done(d0 + 1, 3000, name);
    step(5);
    chk({name, " frame_done count"}, done_cnt - d0, 1);
    if (cap.size() > base) chk({name, " latency"}, cap_cyc[base] - pc, 3);
    else                   chk({name, " no byte"}, cap.size(), base + 1);
    chk({name, " byte count"}, cap.size() - base, NBYTES);
    check_frame(name, base, e);
  endtask

  initial begin
    vec_t   vt[4];
    frame_t e;
    int     base;
    int     d0;
    int     pc;
    int     tc;
    int     n;

    vt[0] = '{16'hA5C3, 10'b1000000011, 4'd1, 48'hC1_29_1C_0E_40_43};
    vt[1] = '{16'hFFFF, 10'h3FF,        4'hF, 48'hCF_3F_3F_3F_7F_43};
    vt[2] = '{16'h0000, 10'h000,        4'h0, 48'hC0_00_00_00_40_40};
    vt[3] = '{16'h8001, 10'h101,        4'h7, 48'hC7_20_00_05_40_41};

    // Reset state
    step(3);
    rst = 1'b0;
    step(1);
    chk("reset busy", busy, 0);
    chk("reset tx_send", tx_send, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset tx_byte", tx_byte, 0);

    // Table-driven frames, inputs scrambled after the first byte
    for (int v = 0; v < 4; v++) begin
      w   = vt[v].w;
      ind = vt[v].ind;
      rot = vt[v].rot;
      e   = '0;
      for (int i = 0; i < 6; i++) e[i] = vt[v].exp[47-8*i -: 8];
      e = with_csum(e);
      run_poll($sformatf("vec%0d", v), e, 1'b1);
      step(10);
    end

    // Randomised frames against the reference model, varying UART byte time
    for (int r = 0; r < 6; r++) begin
      byte_cyc = int'($urandom_range(1, 14));
      w        = 16'($urandom);
      ind      = 10'($urandom);
      rot      = 4'($urandom);
      e        = ref_frame(w, ind, rot);
      run_poll($sformatf("rand%0d", r), e, 1'b1);
      step(int'($urandom_range(1, 20)));
    end
    byte_cyc = 10;

    // Poll held off by a busy UART
    w   = 16'h1234;
    ind = 10'h2A5;
    rot = 4'h9;
    e   = ref_frame(w, ind, rot);
    base      = cap.size();
    d0        = done_cnt;
    hold_busy = 1'b1;
    pulse_poll(pc);
    step(50);
    chk("holdoff no send", cap.size() - base, 0);
    chk("holdoff busy", busy, 1);
    hold_busy = 1'b0;
    wait_done(d0 + 1, 2000, "holdoff");
    chk("holdoff byte count", cap.size() - base, NBYTES);
    check_frame("holdoff", base, e);
    step(10);

    // UART never raises busy: start timeout advances each byte
    uart_en = 1'b0;
    base    = cap.size();
    d0      = done_cnt;
    pulse_poll(pc);
    wait_done(d0 + 1, 1000, "tmo");
    if (done_cycs.size() > d0)
      chk("tmo frame_done cycle", done_cycs[d0] - pc, 12 + 10 * (NBYTES - 1));
    else
      chk("tmo frame_done missing", done_cycs.size(), d0 + 1);
    if (cap.size() > base + 1) chk("tmo byte spacing", cap_cyc[base+1] - cap_cyc[base], 10);
    else                       chk("tmo spacing missing", cap.size(), base + 2);
    check_frame("tmo", base, e);
    uart_en = 1'b1;
    step(10);

    // Three polls during a frame coalesce into one follow-up frame
    w   = 16'hBEEF;
    ind = 10'h155;
    rot = 4'h3;
    e   = ref_frame(w, ind, rot);
    base = cap.size();
    d0   = done_cnt;
    pulse_poll(pc);
    n = 0;
    while (cap.size() == base && n < 100) begin
      step(1);
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      pulse_poll(pc);
      step(15);
    end
    wait_done(d0 + 2, 3000, "coalesce");
    step(300);
    chk("coalesce frame count", done_cnt - d0, 2);
    chk("coalesce byte count", cap.size() - base, 2 * NBYTES);
    check_frame("coalesce f0", base, e);
    check_frame("coalesce f1", base + NBYTES, e);
    if (done_cycs.size() > d0 && cap.size() > base + NBYTES)
      chk("coalesce restart gap", cap_cyc[base+NBYTES] - done_cycs[d0], 3);
    else
      chk("coalesce restart missing", cap.size(), base + NBYTES + 1);

    // Auto-report every AUTO_MS ticks
    for (int k = 1; k <= 9; k++) begin
      base = cap.size();
      pulse_tick(tc);
      step(149);
      if (k % AUTO_MS == 0) begin
        chk($sformatf("auto tick%0d bytes", k), cap.size() - base, NBYTES);
        if (cap.size() > base) chk($sformatf("auto tick%0d latency", k), cap_cyc[base] - tc, 3);
        else                   chk($sformatf("auto tick%0d no byte", k), cap.size(), base + 1);
      end else begin
        chk($sformatf("auto tick%0d idle", k), cap.size() - base, 0);
      end
    end

    // Auto expiry and poll in the same cycle give a single frame
    base = cap.size();
    d0   = done_cnt;
    pulse_tick(tc);
    step(20);
    pulse_tick(tc);
    step(20);
    chk("auto+poll pre idle", cap.size() - base, 0);
    poll     = 1'b1;
    tick_1ms = 1'b1;
    step(1);
    poll     = 1'b0;
    tick_1ms = 1'b0;
    step(300);
    chk("auto+poll frames", done_cnt - d0, 1);
    chk("auto+poll bytes", cap.size() - base, NBYTES);

    // Reset during B2 abandons the frame and drops a simultaneous poll
    w   = 16'h0F0F;
    ind = 10'h0C3;
    rot = 4'hA;
    e   = ref_frame(w, ind, rot);
    base = cap.size();
    d0   = done_cnt;
    pulse_poll(pc);
    n = 0;
    while (cap.size() < base + 3 && n < 200) begin
      step(1);
      n++;
    end
    chk("rst B2 reached", cap.size() - base, 3);
    rst  = 1'b1;
    poll = 1'b1;
    step(1);
    rst  = 1'b0;
    poll = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst tx_send", tx_send, 0);
    step(150);
    chk("rst no more bytes", cap.size() - base, 3);
    chk("rst no frame_done", done_cnt - d0, 0);
    run_poll("post-rst", e, 1'b0);

    chk("tx_byte hold", stab_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
